// File: rtl/arf096b256e1r1w0cbbeheaa4acw_wr_stage.sv
// Write-port front end for the 96x256 1R1W register file.
// Stage+skid buffer, out-of-range filter, one-hot byte-masked array write.
module arf096b256e1r1w0cbbeheaa4acw_wr_stage #(
    parameter int DEPTH   = 96,
    parameter int DWIDTH  = 256,
    parameter int AWIDTH  = 7,
    parameter int BEWIDTH = DWIDTH / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [AWIDTH-1:0]  wr_addr,
    input  logic [DWIDTH-1:0]  wr_data,
    input  logic [BEWIDTH-1:0] wr_be,
    input  logic               arr_busy,
    output logic [DEPTH-1:0]   arr_wen,
    output logic [DWIDTH-1:0]  arr_wdata,
    output logic [BEWIDTH-1:0] arr_wbe,
    input  logic [AWIDTH-1:0]  rd_addr,
    output logic               rd_hazard,
    output logic               err_oob,
    output logic [7:0]         oob_cnt
);

    localparam int AW1 = AWIDTH + 1;

    logic               s_valid_q, s_valid_d;
    logic [AWIDTH-1:0]  s_addr_q, s_addr_d;
    logic [DWIDTH-1:0]  s_data_q, s_data_d;
    logic [BEWIDTH-1:0] s_be_q, s_be_d;
    logic               k_valid_q, k_valid_d;
    logic [AWIDTH-1:0]  k_addr_q, k_addr_d;
    logic [DWIDTH-1:0]  k_data_q, k_data_d;
    logic [BEWIDTH-1:0] k_be_q, k_be_d;
    logic               err_oob_q, err_oob_d;
    logic [7:0]         oob_cnt_q, oob_cnt_d;

    logic issue;
    logic accept;
    logic in_rng;
    logic acc_in;
    logic acc_oob;

    assign wr_ready = rst & ~k_valid_q;
    assign err_oob  = err_oob_q;
    assign oob_cnt  = oob_cnt_q;

    // Gating with rst keeps the array from capturing on a reset edge.
    assign issue   = rst & s_valid_q & ~arr_busy;
    assign accept  = wr_valid & wr_ready;
    assign in_rng  = {1'b0, wr_addr} < AW1'(DEPTH);
    assign acc_in  = accept & in_rng;
    assign acc_oob = accept & ~in_rng;

    always_comb begin
        s_valid_d = s_valid_q;
        s_addr_d  = s_addr_q;
        s_data_d  = s_data_q;
        s_be_d    = s_be_q;
        k_valid_d = k_valid_q;
        k_addr_d  = k_addr_q;
        k_data_d  = k_data_q;
        k_be_d    = k_be_q;
        if (issue && k_valid_q) begin
            s_valid_d = 1'b1;
            s_addr_d  = k_addr_q;
            s_data_d  = k_data_q;
            s_be_d    = k_be_q;
            k_valid_d = acc_in;
            if (acc_in) begin
                k_addr_d = wr_addr;
                k_data_d = wr_data;
                k_be_d   = wr_be;
            end
        end else if (!s_valid_q || issue) begin
            s_valid_d = acc_in;
            if (acc_in) begin
                s_addr_d = wr_addr;
                s_data_d = wr_data;
                s_be_d   = wr_be;
            end
        end else if (acc_in) begin
            k_valid_d = 1'b1;
            k_addr_d  = wr_addr;
            k_data_d  = wr_data;
            k_be_d    = wr_be;
        end
    end

    always_comb begin
        err_oob_d = acc_oob;
        oob_cnt_d = oob_cnt_q;
        if (acc_oob && oob_cnt_q != 8'hFF) begin
            oob_cnt_d = oob_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_valid_q <= 1'b0;
            k_valid_q <= 1'b0;
            err_oob_q <= 1'b0;
            oob_cnt_q <= 8'd0;
        end else begin
            s_valid_q <= s_valid_d;
            k_valid_q <= k_valid_d;
            err_oob_q <= err_oob_d;
            oob_cnt_q <= oob_cnt_d;
        end
    end

    // Payload flops need no reset: they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        s_addr_q <= s_addr_d;
        s_data_q <= s_data_d;
        s_be_q   <= s_be_d;
        k_addr_q <= k_addr_d;
        k_data_q <= k_data_d;
        k_be_q   <= k_be_d;
    end

    always_comb begin
        arr_wen   = '0;
        arr_wdata = '0;
        arr_wbe   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            arr_wen[i] = issue && (s_addr_q == AWIDTH'(i));
        end
        for (int b = 0; b < BEWIDTH; b++) begin
            if (issue && s_be_q[b]) begin
                arr_wdata[8*b +: 8] = s_data_q[8*b +: 8];
            end
        end
        if (issue) begin
            arr_wbe = s_be_q;
        end
    end

    always_comb begin
        rd_hazard = (s_valid_q && s_addr_q == rd_addr)
                  | (k_valid_q && k_addr_q == rd_addr);
    end

endmodule
